ddc_mixer: RTL

Parametrised digital down-converter front end: integrated phase-accumulator NCO, quarter-wave sine/cosine LUT and complex mixer with convergent rounding and saturation. It replaces the vendor DDS plus complex-multiplier chain in the receive path. It takes real ADC samples and produces baseband I/Q at the input rate for the CORDIC and decimation stages.

---
 rtl/ddc_mixer_pkg.sv | 61 ++++++
 rtl/ddc_mixer_if.sv | 24 ++
 rtl/nco_quarter_lut.sv | 88 ++++++++
 rtl/ddc_mixer.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/ddc_mixer_pkg.sv
// Shared definitions for the down-converter: width defaults, quadrant type,
// quarter-wave LUT generator and the convergent round/saturate helper.
package ddc_pkg;

   localparam int ACC_W_DEF      = 32;
   localparam int LUT_ADDR_W_DEF = 10;
   localparam int LUT_W_DEF      = 14;
   localparam int IN_W_DEF       = 8;
   localparam int OUT_W_DEF      = 8;

   typedef enum logic [1:0] {
      Q0 = 2'd0,
      Q1 = 2'd1,
      Q2 = 2'd2,
      Q3 = 2'd3
   } quad_t;

   // Result of round/saturate: value in the low OUT_W bits plus a saturation flag.
   typedef struct packed {
      logic signed [31:0] val;
      logic               sat;
   } rnd_t;

   // Quarter-wave sine entry k, sampled at the bin centre (k+0.5) so that
   // mirrored addresses (a and ~a) give exact sin/cos symmetry.
   function automatic int lut_entry(input int k, input int addr_w, input int lut_w);
      real amp;
      real ang;
      amp = real'((32'sd1 <<< (lut_w - 32'sd1)) - 32'sd1);
      ang = (3.14159265358979 / 2.0) * (real'(k) + 0.5) / real'(32'sd1 <<< addr_w);
      return $rtoi(amp * $sin(ang) + 0.5);
   endfunction

   // Drop f LSBs with round-half-to-even, then clamp to an ow-bit signed range.
   function automatic rnd_t conv_round_sat(input logic signed [63:0] x,
                                           input int f, input int ow);
      logic signed [63:0] bias;
      logic signed [63:0] sum;
      logic signed [63:0] q;
      logic signed [63:0] maxv;
      logic signed [63:0] minv;
      rnd_t r;
      bias = ((64'sd1 <<< (f - 32'sd1)) - 64'sd1) + ((x >>> f) & 64'sd1);
      sum  = x + bias;
      q    = sum >>> f;
      maxv = (64'sd1 <<< (ow - 32'sd1)) - 64'sd1;
      minv = -(64'sd1 <<< (ow - 32'sd1));
      if (q > maxv) begin
         r.val = maxv[31:0];
         r.sat = 1'b1;
      end else if (q < minv) begin
         r.val = minv[31:0];
         r.sat = 1'b1;
      end else begin
         r.val = q[31:0];
         r.sat = 1'b0;
      end
      return r;
   endfunction

endpackage

// File: rtl/ddc_mixer_if.sv
// Sample-in / baseband-out stream bundle of the down-converter.
interface ddc_mixer_if
   import ddc_pkg::*;
#(
   parameter int IN_W  = IN_W_DEF,
   parameter int OUT_W = OUT_W_DEF
);
   logic                    s_valid;
   logic signed [IN_W-1:0]  s_data;
   logic                    m_valid;
   logic signed [OUT_W-1:0] m_i;
   logic signed [OUT_W-1:0] m_q;
   logic                    m_sat;

   modport master (
      output s_valid, s_data,
      input  m_valid, m_i, m_q, m_sat
   );

   modport slave (
      input  s_valid, s_data,
      output m_valid, m_i, m_q, m_sat
   );
endinterface

// File: rtl/nco_quarter_lut.sv
// Quarter-wave sine ROM with registered read, followed by a registered
// quadrant fold producing cos and -sin for the e^-jθ mixer.
module nco_quarter_lut
   import ddc_pkg::*;
#(
   parameter int LUT_ADDR_W = LUT_ADDR_W_DEF,
   parameter int LUT_W      = LUT_W_DEF
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    ce,
   input  logic [LUT_ADDR_W+1:0]   i_phase,
   output logic signed [LUT_W-1:0] o_cos,
   output logic signed [LUT_W-1:0] o_nsin
);

   localparam int DEPTH = 32'sd1 <<< LUT_ADDR_W;

   logic signed [LUT_W-1:0] w_rom [DEPTH];
   logic [LUT_ADDR_W-1:0]   w_addr;
   logic [LUT_ADDR_W-1:0]   w_addr_inv;
   quad_t                   w_quad;

   logic signed [LUT_W-1:0] r_t_a;
   logic signed [LUT_W-1:0] r_t_na;
   quad_t                   r_quad;
   logic signed [LUT_W-1:0] r_cos;
   logic signed [LUT_W-1:0] r_nsin;

   genvar k;
   generate
      for (k = 0; k < DEPTH; k++) begin : g_rom
         assign w_rom[k] = LUT_W'(lut_entry(k, LUT_ADDR_W, LUT_W));
      end
   endgenerate

   assign w_quad     = quad_t'(i_phase[LUT_ADDR_W+1 -: 2]);
   assign w_addr     = i_phase[LUT_ADDR_W-1:0];
   assign w_addr_inv = ~w_addr;

   // ROM read of both mirrored entries, quadrant carried alongside.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_t_a  <= {LUT_W{1'b0}};
         r_t_na <= {LUT_W{1'b0}};
         r_quad <= Q0;
      end else if (ce) begin
         r_t_a  <= w_rom[w_addr];
         r_t_na <= w_rom[w_addr_inv];
         r_quad <= w_quad;
      end
   end

   // Fold the quarter-wave samples into full-circle cos and -sin.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cos  <= {LUT_W{1'b0}};
         r_nsin <= {LUT_W{1'b0}};
      end else if (ce) begin
         case (r_quad)
            Q0: begin
               r_cos  <= r_t_na;
               r_nsin <= -r_t_a;
            end
            Q1: begin
               r_cos  <= -r_t_a;
               r_nsin <= -r_t_na;
            end
            Q2: begin
               r_cos  <= -r_t_na;
               r_nsin <= r_t_a;
            end
            Q3: begin
               r_cos  <= r_t_a;
               r_nsin <= r_t_na;
            end
            default: begin
               r_cos  <= r_t_na;
               r_nsin <= -r_t_a;
            end
         endcase
      end
   end

   assign o_cos  = r_cos;
   assign o_nsin = r_nsin;

endmodule

// File: rtl/ddc_mixer.sv
// Digital down-converter front end: phase accumulator NCO, quarter-wave LUT,
// complex mixer and convergent round/saturate output, five pipeline stages.
module ddc_mixer
   import ddc_pkg::*;
#(
   parameter int ACC_W      = ACC_W_DEF,
   parameter int LUT_ADDR_W = LUT_ADDR_W_DEF,
   parameter int LUT_W      = LUT_W_DEF,
   parameter int IN_W       = IN_W_DEF,
   parameter int OUT_W      = OUT_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ce,
   input  logic [ACC_W-1:0] i_tune,
   input  logic             i_tune_load,
   input  logic             i_sync,
   ddc_mixer_if.slave       bus
);

   localparam int PH_W   = LUT_ADDR_W + 2;
   localparam int PROD_W = IN_W + LUT_W;
   localparam int F      = LUT_W - 1;

   logic [ACC_W-1:0]         r_acc;
   logic [ACC_W-1:0]         r_tune;
   logic                     r_s1_valid;
   logic [PH_W-1:0]          r_s1_phase;
   logic signed [IN_W-1:0]   r_s1_data;
   logic                     r_s2_valid;
   logic signed [IN_W-1:0]   r_s2_data;
   logic                     r_s3_valid;
   logic signed [IN_W-1:0]   r_s3_data;
   logic                     r_s4_valid;
   logic signed [PROD_W-1:0] r_s4_i;
   logic signed [PROD_W-1:0] r_s4_q;
   logic                     r_m_valid;
   logic signed [OUT_W-1:0]  r_m_i;
   logic signed [OUT_W-1:0]  r_m_q;
   logic                     r_m_sat;

   logic                     w_accept;
   logic [ACC_W-1:0]         w_phase_used;
   logic [ACC_W-1:0]         w_acc_next;
   logic signed [LUT_W-1:0]  w_cos;
   logic signed [LUT_W-1:0]  w_nsin;
   rnd_t                     w_rnd_i;
   rnd_t                     w_rnd_q;
   logic                     w_unused;

   assign w_accept     = ce & bus.s_valid;
   assign w_phase_used = i_sync ? {ACC_W{1'b0}} : r_acc;
   assign w_acc_next   = w_phase_used + r_tune;

   // Tuning word register; a new word only affects later accumulator updates.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_tune <= {ACC_W{1'b0}};
      end else if (ce && i_tune_load) begin
         r_tune <= i_tune;
      end
   end

   // Phase accumulator advances once per accepted sample.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_acc <= {ACC_W{1'b0}};
      end else if (w_accept) begin
         r_acc <= w_acc_next;
      end
   end

   // S1..S3 valid/sample delay line matching the LUT latency.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_s1_valid <= 1'b0;
         r_s1_phase <= {PH_W{1'b0}};
         r_s1_data  <= {IN_W{1'b0}};
         r_s2_valid <= 1'b0;
         r_s2_data  <= {IN_W{1'b0}};
         r_s3_valid <= 1'b0;
         r_s3_data  <= {IN_W{1'b0}};
      end else if (ce) begin
         r_s1_valid <= bus.s_valid;
         if (bus.s_valid) begin
            r_s1_phase <= w_phase_used[ACC_W-1 -: PH_W];
            r_s1_data  <= bus.s_data;
         end
         r_s2_valid <= r_s1_valid;
         r_s2_data  <= r_s1_data;
         r_s3_valid <= r_s2_valid;
         r_s3_data  <= r_s2_data;
      end
   end

   nco_quarter_lut #(
      .LUT_ADDR_W (LUT_ADDR_W),
      .LUT_W      (LUT_W)
   ) u_lut (
      .clk     (clk),
      .reset   (reset),
      .ce      (ce),
      .i_phase (r_s1_phase),
      .o_cos   (w_cos),
      .o_nsin  (w_nsin)
   );

   // S4: full-precision complex mix, I = x*cos, Q = x*(-sin).
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_s4_valid <= 1'b0;
         r_s4_i     <= {PROD_W{1'b0}};
         r_s4_q     <= {PROD_W{1'b0}};
      end else if (ce) begin
         r_s4_valid <= r_s3_valid;
         r_s4_i     <= PROD_W'(r_s3_data) * PROD_W'(w_cos);
         r_s4_q     <= PROD_W'(r_s3_data) * PROD_W'(w_nsin);
      end
   end

   assign w_rnd_i  = conv_round_sat(64'(r_s4_i), F, OUT_W);
   assign w_rnd_q  = conv_round_sat(64'(r_s4_q), F, OUT_W);
   assign w_unused = ^{w_rnd_i.val[31:OUT_W], w_rnd_q.val[31:OUT_W]};

   // S5: registered rounded/saturated outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_m_valid <= 1'b0;
         r_m_i     <= {OUT_W{1'b0}};
         r_m_q     <= {OUT_W{1'b0}};
         r_m_sat   <= 1'b0;
      end else if (ce) begin
         r_m_valid <= r_s4_valid;
         r_m_i     <= w_rnd_i.val[OUT_W-1:0];
         r_m_q     <= w_rnd_q.val[OUT_W-1:0];
         r_m_sat   <= w_rnd_i.sat | w_rnd_q.sat;
      end
   end

   assign bus.m_valid = r_m_valid;
   assign bus.m_i     = r_m_i;
   assign bus.m_q     = r_m_q;
   assign bus.m_sat   = r_m_sat;

endmodule
